// File: rtl/ebike_pkg.sv
// Shared e-bike sensor definitions: cadence FSM states, period saturation value
// and the two prescaler widths.
package ebike_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2
  } cad_state_t;

  localparam int PER_MAX  = 255;
  localparam int PRE_FAST = 8;
  localparam int PRE_SLOW = 16;

  function automatic int pre_bits(input int fast_sim);
    return (fast_sim != 0) ? PRE_FAST : PRE_SLOW;
  endfunction

endpackage

// File: rtl/cadence_avg4.sv
// Four-sample running mean of captured pedal periods; only built when
// CADENCE_AVG_EN is defined (otherwise this file contributes no module).
`ifdef CADENCE_AVG_EN
module cadence_avg4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       valid,
  input  logic       clear,
  output logic [7:0] mean
);
  logic [3:0][7:0] hist_q;
  logic            empty_q;
  logic [9:0]      sum;

  // First sample after a clear seeds every slot so the mean is right immediately.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hist_q  <= '0;
      empty_q <= 1'b1;
    end else if (valid) begin
      empty_q <= 1'b0;
      hist_q  <= empty_q ? {4{sample}} : {hist_q[2:0], sample};
    end
  end

  assign sum  = 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'(hist_q[3]);
  assign mean = sum[9:2];
endmodule
`endif

// File: rtl/cadence_meas.sv
// Pedal cadence period measurement in prescaler ticks with stop detection.
// Define CADENCE_AVG_EN to report a 4-sample mean instead of the raw period.
module cadence_meas
  import ebike_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cadence_rise,
  output logic [7:0] cadence_per,
  output logic       not_pedaling,
  output logic       per_vld
);
  localparam int         PRE     = pre_bits(FAST_SIM);
  localparam logic [7:0] PER_SAT = 8'(PER_MAX);

  cad_state_t     state_q;
  logic [PRE-1:0] pre_q;
  logic [7:0]     cnt_q;
  logic           np_q;
  logic           vld_q;
  logic           tick;
  logic           sat;
  logic           cap;
  logic           stop;

  // A rise forces the prescaler to 0 for that cycle, so it never ticks and
  // the following cycle already counts 1.
  assign tick = (pre_q == '1) && !cadence_rise;
  assign sat  = (cnt_q == PER_SAT);
  assign cap  = cadence_rise && (state_q != STOPPED);
  assign stop = sat && !cadence_rise && (state_q != STOPPED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      pre_q   <= '0;
      cnt_q   <= '0;
      np_q    <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      pre_q <= cadence_rise ? PRE'(1) : pre_q + PRE'(1);
      if (cadence_rise)      cnt_q <= '0;
      else if (tick && !sat) cnt_q <= cnt_q + 8'd1;
      vld_q <= cap;
      case (state_q)
        STOPPED: if (cadence_rise) state_q <= ARMED;
        ARMED, RUNNING: begin
          // A rise on the saturated count is still a valid 255 period.
          if (cadence_rise) begin
            state_q <= RUNNING;
            np_q    <= 1'b0;
          end else if (sat) begin
            state_q <= STOPPED;
            np_q    <= 1'b1;
          end
        end
        default: state_q <= STOPPED;
      endcase
    end
  end

`ifdef CADENCE_AVG_EN
  logic [7:0] mean;

  cadence_avg4 u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (cnt_q),
    .valid  (cap),
    .clear  (stop),
    .mean   (mean)
  );

  assign cadence_per = np_q ? PER_SAT : mean;
`else
  logic [7:0] per_q;

  always_ff @(posedge clk) begin
    if (!rst_n || stop) per_q <= PER_SAT;
    else if (cap)       per_q <= cnt_q;
  end

  assign cadence_per = per_q;
`endif

  assign not_pedaling = np_q;
  assign per_vld      = vld_q;
endmodule

// File: tb/tb_cadence_meas.sv
// Directed scoreboard bench for cadence_meas: four instances run in parallel
// (nominal periods, silent saturation, rise on saturation, averaging pattern).
module tb_cadence_meas;
  localparam int N     = 4;
  localparam int END_C = 65290;

  logic               clk = 1'b0;
  logic [N-1:0]       rst_n;
  logic [N-1:0]       rise;
  logic [N-1:0]       np;
  logic [N-1:0]       vld;
  logic [N-1:0][7:0]  per;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sb_q[N][$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    cadence_meas #(.FAST_SIM(1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[i]),
      .cadence_rise (rise[i]),
      .cadence_per  (per[i]),
      .not_pedaling (np[i]),
      .per_vld      (vld[i])
    );
  end

`ifdef CADENCE_AVG_EN
  int hist[N][4];
  bit hist_ok[N];
`endif

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d: observed %0d expected %0d", tag, inst, cyc, obs, exp);
    end
  endtask

  // Push the value cadence_per must show with the per_vld for this capture.
  task automatic expect_cap(input int inst, input int raw);
`ifdef CADENCE_AVG_EN
    if (!hist_ok[inst]) begin
      for (int k = 0; k < 4; k++) hist[inst][k] = raw;
      hist_ok[inst] = 1'b1;
    end else begin
      for (int k = 3; k > 0; k--) hist[inst][k] = hist[inst][k-1];
      hist[inst][0] = raw;
    end
    sb_q[inst].push_back((hist[inst][0] + hist[inst][1] + hist[inst][2] + hist[inst][3]) >> 2);
`else
    sb_q[inst].push_back(raw);
`endif
  endtask

  task automatic model_clear(input int inst);
`ifdef CADENCE_AVG_EN
    hist_ok[inst] = 1'b0;
`else
    sb_q[inst].delete();
`endif
  endtask

  initial begin
    int exp_per;
    rst_n = '0;
    rise  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("reset_per", i, per[i], 255);
      chk("reset_np", i, np[i], 1);
      chk("reset_vld", i, vld[i], 0);
    end
    rst_n = '1;

    for (int c = 0; c <= END_C; c++) begin
      cyc = c;
      rise[0] = (c == 0 || c == 25600 || c == 51200 || c == 53760 || c == 53761 ||
                 c == 55100 || c == 56380);
      rise[1] = (c == 0 || c == 1);
      rise[2] = (c == 0 || c == 1 || c == 65281);
      rise[3] = (c == 0 || c == 2560 || c == 5120 || c == 7680 || c == 12800);
      rst_n[0] = (c != 55000);

      if (c == 25600 || c == 51200) expect_cap(0, 100);
      if (c == 53760) expect_cap(0, 10);
      if (c == 53761) expect_cap(0, 0);
      if (c == 55000) model_clear(0);
      if (c == 56380) expect_cap(0, 5);
      if (c == 1) begin
        expect_cap(1, 0);
        expect_cap(2, 0);
      end
      if (c == 65281) expect_cap(2, 255);
      if (c == 2560 || c == 5120 || c == 7680) expect_cap(3, 10);
      if (c == 12800) expect_cap(3, 20);

      @(negedge clk);
      cyc = c + 1;

      for (int i = 0; i < N; i++) begin
        chk("per_vld", i, vld[i], (sb_q[i].size() != 0));
        if (vld[i] === 1'b1 && sb_q[i].size() != 0) begin
          exp_per = sb_q[i].pop_front();
          chk("cadence_per", i, per[i], exp_per);
          chk("not_pedaling_at_vld", i, np[i], 0);
        end
      end

      case (c)
        0:     begin chk("arm_no_vld", 0, vld[0], 0); chk("arm_np", 0, np[0], 1);
                     chk("arm_per", 0, per[0], 255); end
        25600: chk("first_cap_np", 0, np[0], 0);
        55000: begin chk("rst_per", 0, per[0], 255); chk("rst_np", 0, np[0], 1);
                     chk("rst_vld", 0, vld[0], 0); end
        55100: begin chk("rearm_np", 0, np[0], 1); chk("rearm_per", 0, per[0], 255); end
        65280: begin chk("presat_np", 1, np[1], 0); chk("presat_per", 1, per[1], 0); end
        65281: begin chk("sat_np", 1, np[1], 1); chk("sat_per", 1, per[1], 255);
                     chk("sat_vld", 1, vld[1], 0); chk("sat_rise_np", 2, np[2], 0); end
        65282: chk("sat_rise_np_hold", 2, np[2], 0);
        default: ;
      endcase
    end

    for (int i = 0; i < N; i++) chk("sb_drained", i, sb_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cadence_meas.md
CADENCE_MEAS -- requirements
Module: cadence_meas

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, meaning: selects the short prescale (PRE=8) when 1 and the long prescale (PRE=16) when 0.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port cadence_rise, input, 1 bit: one-cycle pulse marking a filtered pedal-sensor rising edge.
REQ-005 SHALL have port cadence_per, output, 8 bits: pedal period in prescaler ticks; 255 means stopped or too slow.
REQ-006 SHALL have port not_pedaling, output, 1 bit: high while no valid pedal period exists.
REQ-007 SHALL have port per_vld, output, 1 bit: one-cycle pulse issued when cadence_per is updated with a measured value.

Function
REQ-008 SHALL run a PRE-bit prescaler that increments every cycle, wraps, and clears to 0 in any cycle where cadence_rise=1.
REQ-009 SHALL assert an internal tick in each cycle where the prescaler equals 2^PRE-1 and cadence_rise=0.
REQ-010 SHALL keep an 8-bit period counter that increments on tick, saturates at 255, and clears to 0 on cadence_rise.
REQ-011 SHALL implement the states STOPPED, ARMED and RUNNING.
REQ-012 SHALL, in STOPPED, hold not_pedaling=1 and cadence_per=255, and move to ARMED on cadence_rise without capturing.
REQ-013 SHALL, in ARMED, move to RUNNING on cadence_rise, capturing the counter value into cadence_per, clearing not_pedaling and pulsing per_vld, all in the cycle after the rise.
REQ-014 SHALL, in RUNNING, capture on every cadence_rise, pulsing per_vld for one cycle, with the updated cadence_per visible one cycle after the rise.
REQ-015 SHALL, when the counter reaches 255 in ARMED or RUNNING with no rise that cycle, move to STOPPED, set cadence_per=255 and not_pedaling=1, and leave per_vld low.
REQ-016 SHALL give a coincident cadence_rise priority over saturation: the value 255 is captured as a valid period and the state stays RUNNING (or enters RUNNING from ARMED).
REQ-017 SHALL produce exactly one per_vld pulse for back-to-back rises on consecutive cycles, with the second rise capturing 0.
REQ-018 SHALL never pulse per_vld in STOPPED.

Reset
REQ-019 SHALL, while rst_n=0 at a clk edge, set state=STOPPED, clear the prescaler and counter, set cadence_per=255 and not_pedaling=1, and clear per_vld.
REQ-020 SHALL, on reset mid-measurement, discard the partial interval, so that the first rise after reset only arms.

Configuration
REQ-021 SHALL, when CADENCE_AVG_EN is defined, drive cadence_per from the mean of the last 4 captured samples (10-bit sum shifted right by 2, truncated).
REQ-022 SHALL, with CADENCE_AVG_EN defined, fill all 4 history entries with the first sample on the ARMED-to-RUNNING capture, and clear the history on entry to STOPPED.
REQ-023 SHALL, when CADENCE_AVG_EN is undefined, drive cadence_per from the raw latest sample and build no history logic.

Structure
REQ-024 SHALL take the state enum (cad_state_t), PER_MAX=255 and the PRE values 8 and 16 from the shared package ebike_pkg.
REQ-025 SHALL place the CADENCE_AVG_EN averaging in a sub-module cadence_avg4 (sample in, valid in, clear in, 8-bit mean out).

Verification
REQ-026 SHALL cover: with FAST_SIM=1, rises at cycles 0, 25600 and 51200 -> no per_vld at cycle 1; per_vld at 25601 with cadence_per=100 and not_pedaling=0; per_vld at 51201 with cadence_per=100.
REQ-027 SHALL cover: in RUNNING, no rise for 255*256 cycles -> not_pedaling=1 and cadence_per=255 at saturation, with per_vld never asserted.
REQ-028 SHALL cover: a rise in the same cycle the counter reaches 255 -> per_vld=1, cadence_per=255, not_pedaling=0.
REQ-029 SHALL cover: rst_n low for 1 cycle mid-interval -> outputs 255/1/0; the next rise only arms and the following rise captures correctly.
REQ-030 SHALL cover: with CADENCE_AVG_EN defined, samples 100, 100, 100, 200 -> cadence_per sequence 100, 100, 100, 125.
REQ-031 SHALL cover: rises on two consecutive cycles in RUNNING -> the second capture gives cadence_per=0 with a single per_vld pulse for it.
